// File: rtl/timer_irq_pkg.sv
// timer_irq shared definitions.
// Register map, CTRL field positions, modes and FSM encoding.
package timer_irq_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped 32-bit down-counter timer.
// One-shot (sticky irq) or auto-reload (one-cycle irq pulse).
module timer_irq
    import timer_irq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    state_e      state_q;

    state_e      state_d;
    logic [31:0] count_d;
    logic        en_clr;
    logic        flag_set;
    logic        flag_clr;

    logic        en;
    logic [1:0]  mode;
    logic        wr_ctrl;
    logic        wr_preset;

    assign en        = ctrl_q[CTRL_EN];
    assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);
    assign irq       = irq_flag_q & ctrl_q[CTRL_IM];

    // Next state, next count and flag/enable side effects of the FSM
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        en_clr   = 1'b0;
        flag_set = 1'b0;
        flag_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = '0;
                    flag_set = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    flag_clr = 1'b1;
                end else begin
                    en_clr = 1'b1;
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // CPU-visible registers; a CPU write beats the FSM on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= {1'b0, MODE_ONESHOT, 1'b0};
            preset_q   <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= wdata[3:0];
            end else if (en_clr) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (wr_preset) begin
                preset_q <= wdata;
            end
            if (wr_ctrl || wr_preset) begin
                irq_flag_q <= 1'b0;
            end else if (flag_set) begin
                irq_flag_q <= 1'b1;
            end else if (flag_clr) begin
                irq_flag_q <= 1'b0;
            end
        end
    end

    // Combinational register read, no side effects
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed and random stimulus for timer_irq,
// checked every cycle against an elapsed-edge reference model.
module tb_timer_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a run is tracked by its age in edges since
    // the timer left idle (-1 = idle, 0 = loading, 1..len = counting,
    // len+1 = expired).
    logic        m_en = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    logic        m_im = 1'b0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count = '0;
    logic [31:0] m_n = '0;
    logic        m_flag = 1'b0;
    int          m_age = -1;
    int          m_len = 1;

    task automatic model_edge();
        logic        n_en;
        logic        n_flag;
        logic [31:0] n_count;
        int          n_age;
        if (reset) begin
            m_en = 0; m_mode = 0; m_im = 0;
            m_preset = 0; m_count = 0; m_flag = 0;
            m_age = -1;
            return;
        end
        n_en = m_en;
        n_flag = m_flag;
        n_count = m_count;
        n_age = m_age;
        if (m_age < 0) begin
            if (m_en) n_age = 0;
        end else if (m_age == 0) begin
            m_n = m_preset;
            m_len = (m_preset == 0) ? 1 : int'(m_preset);
            n_count = m_preset;
            n_age = 1;
        end else if (m_age <= m_len) begin
            if (!m_en) begin
                n_age = -1;
            end else if (m_age == m_len) begin
                n_count = 0;
                n_flag = 1;
                n_age = m_len + 1;
            end else begin
                n_count = m_n - 32'(m_age);
                n_age = m_age + 1;
            end
        end else begin
            if (m_mode == 2'b01) n_flag = 0;
            else n_en = 0;
            n_age = -1;
        end
        if (we && addr == 2'd0) begin
            n_en = wdata[0];
            m_mode = wdata[2:1];
            m_im = wdata[3];
            n_flag = 0;
        end
        if (we && addr == 2'd1) begin
            m_preset = wdata;
            n_flag = 0;
        end
        m_en = n_en;
        m_flag = n_flag;
        m_count = n_count;
        m_age = n_age;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [1:0] a,
                        input logic [31:0] d);
        we = w;
        addr = a;
        wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0;
        chk("irq", {31'd0, irq}, {31'd0, m_flag & m_im});
        chk("rdata", rdata, exp_rdata(addr));
    endtask

    task automatic peek_all();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("peek", rdata, exp_rdata(addr));
        end
        addr = 2'd2;
    endtask

    task automatic wait_irq(input int max, output int n);
        n = 0;
        do begin
            step(1'b0, 2'd2, 32'd0);
            n++;
        end while (!irq && n < max);
    endtask

    int n;
    int last;
    int pulses;
    int r;

    initial begin
        reset = 1'b1;
        we = 1'b0;
        addr = 2'd0;
        wdata = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
        peek_all();

        // reset while counting
        step(1, 1, 20);
        step(1, 0, 32'h9);
        repeat (4) step(0, 2, 0);
        reset = 1'b1;
        step(0, 2, 0);
        step(0, 0, 0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("reset_rdata", rdata, 32'd0);
        end
        chk("reset_irq", {31'd0, irq}, 32'd0);
        repeat (20) step(0, 2, 0);

        // one-shot
        step(1, 1, 5);
        step(1, 0, 32'h9);
        wait_irq(20, n);
        chk("oneshot_latency", n, 7);
        repeat (3) step(0, 0, 0);
        chk("oneshot_sticky", {31'd0, irq}, 32'd1);
        chk("oneshot_ctrl", rdata, 32'h8);
        step(1, 1, 5);
        chk("oneshot_clear", {31'd0, irq}, 32'd0);

        // auto-reload
        repeat (3) step(0, 2, 0);
        step(1, 1, 3);
        step(1, 0, 32'hB);
        wait_irq(20, n);
        chk("reload_first", n, 5);
        last = 0;
        pulses = 0;
        for (int i = 1; i <= 18; i++) begin
            step(0, 2, 0);
            if (irq) begin
                pulses++;
                chk("reload_period", i - last, 6);
                last = i;
            end
        end
        chk("reload_pulses", pulses, 3);
        step(1, 0, 0);

        // masked interrupt
        step(1, 1, 2);
        step(1, 0, 32'h1);
        repeat (6) step(0, 2, 0);
        chk("mask_irq", {31'd0, irq}, 32'd0);
        step(1, 0, 32'h8);
        chk("mask_clear", {31'd0, irq}, 32'd0);
        repeat (3) step(0, 2, 0);
        step(1, 0, 32'h9);
        wait_irq(20, n);
        chk("unmasked_latency", n, 4);

        // disable mid-count, then restart from PRESET
        step(1, 1, 10);
        repeat (3) step(0, 2, 0);
        step(1, 0, 32'h9);
        repeat (5) step(0, 2, 0);
        step(1, 0, 32'h8);
        repeat (5) step(0, 2, 0);
        chk("count_frozen", rdata, 32'd6);
        chk("frozen_irq", {31'd0, irq}, 32'd0);
        step(1, 0, 32'h9);
        wait_irq(30, n);
        chk("restart_latency", n, 12);

        // PRESET=0 behaves as 1
        repeat (3) step(0, 2, 0);
        step(1, 1, 0);
        step(1, 0, 32'h9);
        wait_irq(20, n);
        chk("preset0_latency", n, 3);
        step(1, 2, 32'h1234);
        chk("count_ro", rdata, 32'd0);
        step(1, 3, 32'hFFFF);
        peek_all();
        step(1, 0, 0);

        // PRESET change during a run takes effect at next reload
        repeat (3) step(0, 2, 0);
        step(1, 1, 3);
        step(1, 0, 32'hB);
        repeat (3) step(0, 2, 0);
        step(1, 1, 7);
        wait_irq(20, n);
        chk("run_unaffected", n, 1);
        wait_irq(20, n);
        chk("reload_new", n, 10);
        step(1, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 127) == 0) begin
                reset = 1'b1;
                step(0, 0, 0);
                reset = 1'b0;
            end else if (r == 0) begin
                step(1, 0, 32'($urandom_range(0, 15)));
            end else if (r == 1) begin
                step(1, 0, 32'($urandom_range(0, 15)) | 32'h9);
            end else if (r == 2) begin
                step(1, 1, 32'($urandom_range(0, 5)));
            end else if (r == 3) begin
                step(1, 2'(2 + $urandom_range(0, 1)), $urandom);
            end else begin
                step(0, 2'($urandom_range(0, 3)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
